// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wr_arbiter
//  Purpose  : Shares the register-file write port between the pipeline (A)
//             and a queued long-latency source (B), with a pending-write mask.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    input  logic [ADDR_WIDTH-1:0]      a_addr,
    input  logic [DATA_WIDTH-1:0]      a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [ADDR_WIDTH-1:0]      b_addr,
    input  logic [DATA_WIDTH-1:0]      b_data,
    output logic                       we,
    output logic [ADDR_WIDTH-1:0]      a3,
    output logic [DATA_WIDTH-1:0]      wd3,
    output logic                       stall_a,
    output logic [2**ADDR_WIDTH-1:0]   pending_mask
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CNTW-1:0] C_FULL = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   C_MAX  = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STARVE = 2'd2
    } state_t;

    logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CNTW-1:0]       r_count;
    logic [CNTW-1:0]       w_count_n;

    logic                  r_we;
    logic                  r_src_b;
    logic [ADDR_WIDTH-1:0] r_a3;
    logic [DATA_WIDTH-1:0] r_wd3;
    logic                  r_stall_a;

    state_t                r_state;
    state_t                w_state_n;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_n;

    logic                  w_empty;
    logic                  w_push;
    logic                  w_grant_a;
    logic                  w_pop;
    logic [FIFO_DEPTH-1:0] w_occ;
    logic [2**ADDR_WIDTH-1:0] w_pending;

    assign w_empty   = (r_count == '0);
    assign b_ready   = (r_count != C_FULL);
    // Address 0 completes the handshake but never occupies a slot.
    assign w_push    = b_valid && b_ready && (b_addr != '0);
    assign w_grant_a = a_valid && (a_addr != '0);
    assign w_pop     = !w_grant_a && !w_empty;
    assign w_count_n = r_count + CNTW'(w_push) - CNTW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= b_addr;
            r_mem_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_src_b <= 1'b0;
            r_a3    <= '0;
            r_wd3   <= '0;
        end else if (w_grant_a) begin
            r_we    <= 1'b1;
            r_src_b <= 1'b0;
            r_a3    <= a_addr;
            r_wd3   <= a_data;
        end else if (w_pop) begin
            r_we    <= 1'b1;
            r_src_b <= 1'b1;
            r_a3    <= r_mem_addr[r_rd_ptr];
            r_wd3   <= r_mem_data[r_rd_ptr];
        end else begin
            r_we    <= 1'b0;
            r_src_b <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_stall_a <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_stall_a <= (w_state_n == ST_STARVE);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        if (w_pop) begin
            w_cnt_n   = '0;
            w_state_n = (w_count_n != '0) ? ST_WAIT : ST_IDLE;
        end else if (!w_empty) begin
            // Head lost arbitration this cycle; counter saturates at the limit.
            if (r_cnt < C_MAX) w_cnt_n = r_cnt + 1'b1;
            if ((r_state == ST_STARVE) || (r_cnt >= C_MAX - 1'b1))
                w_state_n = ST_STARVE;
            else
                w_state_n = ST_WAIT;
        end else begin
            w_cnt_n   = '0;
            w_state_n = w_push ? ST_WAIT : ST_IDLE;
        end
    end

    generate
        for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_occ
            logic [PW-1:0] w_off;
            assign w_off    = PW'(i) - r_rd_ptr;
            assign w_occ[i] = ({1'b0, w_off} < r_count);
        end
    endgenerate

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_occ[i]) w_pending[r_mem_addr[i]] = 1'b1;
        end
        if (r_we && r_src_b) w_pending[r_a3] = 1'b1;
    end

    assign we           = r_we;
    assign a3           = r_a3;
    assign wd3          = r_wd3;
    assign stall_a      = r_stall_a;
    assign pending_mask = w_pending;

endmodule
`default_nettype wire

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Shares the register file's single write port (WE/A3/WD3) between two requesters. Port A is the in-order pipeline writeback; it is highest priority and has no backpressure. Port B is the long-latency unit (multiply/divide, load return); it uses valid/ready into a small FIFO. The block sits between both writeback sources and the register file, and exports a pending-write scoreboard to the hazard unit.

Parameters:
DATA_WIDTH, 32, write data width
ADDR_WIDTH, 5, register address width (register count = 2**ADDR_WIDTH)
FIFO_DEPTH, 4, port-B queue entries (power of 2, >=2)
MAX_WAIT, 8, consecutive cycles the FIFO head may lose arbitration before STALL_A asserts

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
A_VALID  in  1  pipeline writeback request, always accepted
A_ADDR  in  ADDR_WIDTH  pipeline destination register
A_DATA  in  DATA_WIDTH  pipeline write data
B_VALID  in  1  long-latency result valid
B_READY  out  1  FIFO can accept (= !full)
B_ADDR  in  ADDR_WIDTH  long-latency destination register
B_DATA  in  DATA_WIDTH  long-latency write data
WE  out  1  register file write enable (registered)
A3  out  ADDR_WIDTH  register file write address (registered)
WD3  out  DATA_WIDTH  register file write data (registered)
STALL_A  out  1  request to pipeline to withhold A writes (registered)
PENDING_MASK  out  2**ADDR_WIDTH  bit r=1: a B write to register r is queued or in the output stage

Behaviour:
- Reset (RST_N=0, async): WE=0, A3=0, WD3=0, STALL_A=0, FIFO empty (B_READY=1), wait counter=0, FSM=IDLE, PENDING_MASK=0.
- Enqueue: B_VALID && B_READY at a rising edge -> push {B_ADDR,B_DATA}. B_ADDR==0 completes the handshake but is discarded (not pushed). B_READY=!full; a same-cycle pop does not raise B_READY while full.
- Grant, evaluated each cycle:
  - A_VALID && A_ADDR!=0 -> A wins.
  - Else if FIFO non-empty -> pop head, B wins.
  - A_VALID with A_ADDR==0 is a no-op and frees the slot for B.
- Output stage: the winner is registered. Next cycle WE=1, A3/WD3 = winner's addr/data; otherwise WE=0, A3/WD3 hold. Latency is exactly 1 cycle from request/head to WE.
- B entries retire in FIFO order. A and B writes are not ordered relative to each other; the hazard unit enforces this using PENDING_MASK.
- PENDING_MASK: combinational OR of one-hot(addr) over all occupied FIFO entries, plus A3 when WE=1 and the output-stage source is B. Duplicate addresses keep the bit set until the last such write reaches WE.
- Starvation FSM (registered):
  - IDLE: FIFO empty, counter=0.
  - WAIT: FIFO non-empty and head not granted; counter +1 per lost cycle; reset to 0 on any head grant.
  - STARVE: entered when counter reaches MAX_WAIT; STALL_A=1.
  - STARVE -> WAIT (or IDLE if FIFO empty) on the first head grant; STALL_A=0 the following cycle.
  - An A_VALID arriving despite STALL_A still wins; A is never dropped.
- Full FIFO and A_VALID every cycle: B_READY=0, the B source must hold, and no data is lost.
- Reset mid-operation: FIFO contents are discarded, WE drops immediately (async), PENDING_MASK clears.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Test Plan:
- Reset then A_VALID=1, A_ADDR=5, A_DATA=0xDEADBEEF for 1 cycle -> next cycle WE=1, A3=5, WD3=0xDEADBEEF; following cycle WE=0.
- A_ADDR=0 with B queued {7,0x11} same cycle -> A dropped; next cycle WE=1, A3=7, WD3=0x11; PENDING_MASK[7] 1 -> 0 one cycle after WE.
- Push B {3,0xA},{3,0xB},{9,0xC} with A idle -> WE cycles in order 3/0xA, 3/0xB, 9/0xC; PENDING_MASK[3] stays 1 until the second write's WE cycle ends.
- Hold A_VALID=1 (addr 1) continuously with 4 B entries queued -> B_READY=0; STALL_A=1 after MAX_WAIT=8 lost cycles; drop A_VALID -> head written next cycle, STALL_A=0 one cycle later.
- B_VALID with B_ADDR=0 -> B_READY handshake completes, no WE, PENDING_MASK unchanged.
- Assert RST_N=0 with 3 entries queued and WE=1 -> WE=0 and PENDING_MASK=0 immediately; after release B_READY=1, no stale writes.
